// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register bank write port plus per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [AW*NREQ-1:0]   req_reg,
  input  logic [DW*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 wb_hold,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_reg,
  output logic [AW-1:0]        wr_reg,
  output logic [DW-1:0]        wr_data,
  output logic                 wr_en,
  output logic [2**AW-1:0]     busy,
  output logic                 busy_any
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] rr_ptr, gid, nxt_ptr, idx;
  logic [PW:0] sum;
  logic found;
  logic [2**AW-1:0] busy_nxt;
  // search rr_ptr, rr_ptr+1, ... with an explicit wrap since NREQ need not be a power of 2
  always_comb begin
    req_ready = '0;
    gid = '0;
    found = 1'b0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      idx = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : sum[PW-1:0];
      if (!wb_hold && !found && req_valid[idx]) begin
        found = 1'b1;
        gid = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end
  assign nxt_ptr = (gid == PW'(NREQ-1)) ? '0 : gid + PW'(1);
  // a new issue to the same register outranks the commit of the older producer
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[wr_reg] = 1'b0;
    if (iss_valid) busy_nxt[iss_reg] = 1'b1;
  end
  assign busy_any = |busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      wr_en   <= 1'b0;
      wr_reg  <= '0;
      wr_data <= '0;
      busy    <= '0;
    end else begin
      wr_en <= found;
      busy  <= busy_nxt;
      if (found) begin
        rr_ptr  <= nxt_ptr;
        wr_reg  <= req_reg[AW*gid +: AW];
        wr_data <= req_data[DW*gid +: DW];
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: vector table of grants with a write-queue scoreboard, plus async reset sequences.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] req_valid;
  logic [11:0] req_reg;
  logic [47:0] req_data;
  logic [2:0] req_ready;
  logic wb_hold;
  logic iss_valid;
  logic [3:0] iss_reg;
  logic [3:0] wr_reg;
  logic [15:0] wr_data;
  logic wr_en;
  logic [15:0] busy;
  logic busy_any;

  regfile_wb_arbiter #(.NREQ(3), .DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_reg(req_reg),
    .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .wr_reg(wr_reg),
    .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic        hold;
    logic        iv;
    logic [3:0]  ir;
    logic [11:0] regs;
    logic [2:0]  rdy;
  } vec_t;
  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } wr_t;

  localparam int NV = 31;
  vec_t tbl[NV];
  wr_t q[$];
  logic [15:0] m_busy;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [15:0] dat(input int s, input int i);
    return (s == 0 && i == 0) ? 16'hBEEF : 16'hC000 + 16'(s * 16) + 16'(i);
  endfunction

  task automatic step(input int s);
    vec_t v;
    wr_t e;
    int g;
    v = tbl[s];
    g = -1;
    @(negedge clk);
    req_valid = v.valid;
    wb_hold = v.hold;
    iss_valid = v.iv;
    iss_reg = v.ir;
    req_reg = v.regs;
    for (int i = 0; i < 3; i++) req_data[16*i +: 16] = dat(s, i);
    #1;
    chk($sformatf("ready[%0d]", s), 32'(req_ready), 32'(v.rdy));
    chk($sformatf("busy[%0d]", s), 32'(busy), 32'(m_busy));
    chk($sformatf("busy_any[%0d]", s), 32'(busy_any), 32'(|m_busy));
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("wr_en[%0d]", s), 32'(wr_en), 32'd1);
      chk($sformatf("wr_reg[%0d]", s), 32'(wr_reg), 32'(e.r));
      chk($sformatf("wr_data[%0d]", s), 32'(wr_data), 32'(e.d));
      m_busy[e.r] = 1'b0;
    end else begin
      chk($sformatf("wr_en[%0d]", s), 32'(wr_en), 32'd0);
    end
    if (v.iv) m_busy[v.ir] = 1'b1;
    for (int i = 0; i < 3; i++) if (v.rdy[i]) g = i;
    if (g >= 0) q.push_back('{v.regs[4*g +: 4], dat(s, g)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            valid   hold  iv    ir     regs     ready
    tbl[0]  = '{3'b001, 1'b0, 1'b0, 4'd0, 12'h005, 3'b001};
    tbl[1]  = '{3'b000, 1'b0, 1'b0, 4'd0, 12'h005, 3'b000};
    tbl[2]  = '{3'b000, 1'b0, 1'b0, 4'd0, 12'h005, 3'b000};
    tbl[3]  = '{3'b111, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b010};
    tbl[4]  = '{3'b111, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b100};
    tbl[5]  = '{3'b111, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b001};
    tbl[6]  = '{3'b111, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b010};
    tbl[7]  = '{3'b111, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b100};
    tbl[8]  = '{3'b110, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b010};
    tbl[9]  = '{3'b101, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b100};
    tbl[10] = '{3'b101, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b001};
    tbl[11] = '{3'b101, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b100};
    tbl[12] = '{3'b111, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b001};
    tbl[13] = '{3'b111, 1'b1, 1'b0, 4'd0, 12'hEDC, 3'b000};
    tbl[14] = '{3'b111, 1'b1, 1'b0, 4'd0, 12'hEDC, 3'b000};
    tbl[15] = '{3'b111, 1'b1, 1'b0, 4'd0, 12'hEDC, 3'b000};
    tbl[16] = '{3'b111, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b010};
    tbl[17] = '{3'b000, 1'b0, 1'b0, 4'd0, 12'hEDC, 3'b000};
    tbl[18] = '{3'b000, 1'b0, 1'b1, 4'd7, 12'h000, 3'b000};
    tbl[19] = '{3'b010, 1'b0, 1'b0, 4'd0, 12'h070, 3'b010};
    tbl[20] = '{3'b000, 1'b0, 1'b0, 4'd0, 12'h000, 3'b000};
    tbl[21] = '{3'b000, 1'b0, 1'b1, 4'd7, 12'h000, 3'b000};
    tbl[22] = '{3'b010, 1'b0, 1'b0, 4'd0, 12'h070, 3'b010};
    tbl[23] = '{3'b000, 1'b0, 1'b1, 4'd7, 12'h000, 3'b000};
    tbl[24] = '{3'b001, 1'b0, 1'b1, 4'd9, 12'h009, 3'b001};
    tbl[25] = '{3'b000, 1'b0, 1'b1, 4'd3, 12'h000, 3'b000};
    tbl[26] = '{3'b100, 1'b0, 1'b0, 4'd0, 12'h700, 3'b100};
    tbl[27] = '{3'b000, 1'b0, 1'b0, 4'd0, 12'h000, 3'b000};
    tbl[28] = '{3'b001, 1'b0, 1'b0, 4'd0, 12'h003, 3'b001};
    tbl[29] = '{3'b000, 1'b0, 1'b0, 4'd0, 12'h000, 3'b000};
    tbl[30] = '{3'b000, 1'b0, 1'b0, 4'd0, 12'h000, 3'b000};
    m_busy = '0;
    rst_n = 1'b0;
    req_valid = '0;
    req_reg = '0;
    req_data = '0;
    wb_hold = 1'b0;
    iss_valid = 1'b0;
    iss_reg = '0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_busy_any", 32'(busy_any), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < NV; s++) step(s);
    // async reset while a write sits in the output stage
    @(negedge clk);
    req_valid = 3'b001;
    req_reg = 12'h004;
    req_data = {16'h3333, 16'h2222, 16'h1234};
    iss_valid = 1'b1;
    iss_reg = 4'd12;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    chk("pre_rst_busy12", 32'(busy[12]), 32'd1);
    #1;
    rst_n = 1'b0;
    iss_valid = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_reg", 32'(wr_reg), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req_valid = 3'b111;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    chk("post_rst_wr_en", 32'(wr_en), 32'd1);
    chk("post_rst_wr_data", 32'(wr_data), 32'h1234);
    @(negedge clk);
    req_valid = 3'b110;
    #1;
    chk("post_rst_ready2", 32'(req_ready), 32'b010);
    @(posedge clk);
    #1;
    chk("post_rst_wr_data2", 32'(wr_data), 32'h2222);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-port scheduler for the 16x16-bit register bank.
- Shares the bank's single write port (wr_reg/wr_data/wr_en) between NREQ writeback sources (0=ALU result, 1=memory load, 2=PC/status) using fair round-robin and a valid/ready handshake.
- Keeps a per-register busy scoreboard, set at instruction issue and cleared at bank commit, so the control unit can stall on read-after-write hazards.

Parameters:
- NREQ, 3, number of writeback requesters (2..4)
- DW, 16, data width
- AW, 4, register index width (2**AW registers)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  requester i has a write pending
- req_reg  input  AW*NREQ  target register; slice i = [AW*i +: AW]
- req_data  input  DW*NREQ  write data; slice i = [DW*i +: DW]
- req_ready  output  NREQ  requester i granted this cycle
- wb_hold  input  1  block all new grants while 1
- iss_valid  input  1  instruction issued that will write iss_reg
- iss_reg  input  AW  destination register of issued instruction
- wr_reg  output  AW  to bank wr_reg
- wr_data  output  DW  to bank wr_data
- wr_en  output  1  to bank wr_en
- busy  output  2**AW  scoreboard bit per register
- busy_any  output  1  OR of busy

Behaviour:
- Reset (async, rst_n=0): wr_en=0, wr_reg=0, wr_data=0, busy=0, rr_ptr=0. Bank contents are not touched.
- Arbitration (combinational):
  - If wb_hold=0, grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready is one-hot or zero. req_ready[i] is 1 only for the granted i.
  - req_ready may depend on req_valid. Requesters must not make valid depend on ready.
- Transfer: req_valid[i] & req_ready[i] at a rising edge. The requester must hold valid/reg/data stable until transfer.
- Output stage (registered, latency 1 cycle):
  - On transfer: wr_en<=1, wr_reg<=req_reg[i], wr_data<=req_data[i].
  - With no transfer: wr_en<=0; wr_reg/wr_data hold their last value.
  - The bank writes at the edge following wr_en=1, so valid-to-data-in-bank is 2 edges.
- Pointer: after a transfer from i, rr_ptr<=(i+1) mod NREQ. Unchanged when there is no transfer.
  - Continuous requests from all sources are granted in strict rotation.
  - Any single source waits at most NREQ-1 grants.
- wb_hold=1: no grants and rr_ptr frozen. A write already in the output stage still commits (wr_en=1 that cycle).
- Scoreboard:
  - Clear: at an edge with wr_en=1, busy[wr_reg]<=0 (same edge the bank captures data).
  - Set: at an edge with iss_valid=1, busy[iss_reg]<=1.
  - Set and clear of the same register in the same cycle: set wins (newer producer pending).
  - Set and clear of different registers in the same cycle: both apply.
  - Writes to a register whose busy=0 are legal and leave it 0.
  - busy_any = |busy (combinational from the register).
- No register is hardwired. r0..r15 are treated identically.
- Reset mid-operation: an in-flight output-stage write is dropped (wr_en forced 0). Arbitration restarts at rr_ptr=0 on the first edge after rst_n rises. Requesters keep their valid.
- Widths: no arithmetic on data. The rr_ptr mod NREQ wrap must be explicit (NREQ need not be a power of 2).

Test Plan:
- Reset: drive rst_n=0 mid-write (wr_en=1) -> wr_en, wr_reg, wr_data, busy all 0 immediately, without waiting for a clock edge.
- Single write: req_valid=001, reg=5, data=16'hBEEF -> req_ready=001 that cycle; next cycle wr_en=1, wr_reg=5, wr_data=BEEF; following cycle wr_en=0.
- Round-robin: all three valid continuously with distinct data -> grant order 0,1,2,0,1,2; wr_en=1 every cycle; a source dropping valid is skipped with no bubble.
- Hold: all valid, wb_hold=1 for 3 cycles after one grant to 0 -> write from 0 commits, then 3 cycles wr_en=0, then grant resumes at 1.
- Scoreboard: iss_valid reg=7 -> busy[7]=1 next cycle; write to 7 via req 1 -> busy[7]=0 at the same edge as the bank write. Same-cycle iss_reg=7 and commit to 7 -> busy[7] stays 1.
- Concurrent set/clear: issue reg 3 while committing reg 9 (both busy) -> busy[3]=1, busy[9]=0; busy_any tracks correctly.
